// File: rtl/bomb_countdown.sv
// Countdown timer for the bomb FSM: free-running one-second tick plus a two-digit BCD seconds counter.
// Optional build macro COUNTDOWN_TURBO_EN adds a `turbo` input that shortens the tick to a tenth of a second.
module bomb_countdown #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int LOAD_TENS   = 1,
  parameter int LOAD_ONES   = 6,
  parameter int WARN_SECS   = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       countLoadN,
  input  logic       countEnable,
`ifdef COUNTDOWN_TURBO_EN
  input  logic       turbo,
`endif
  output logic       OneSecPulse,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       timerEnd,
  output logic       lowTime
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] LAST_FULL = PW'(CLK_FREQ_HZ - 1);
`ifdef COUNTDOWN_TURBO_EN
  localparam logic [PW-1:0] LAST_TURBO = PW'(CLK_FREQ_HZ / 10 - 1);
`endif

  if (LOAD_TENS < 0 || LOAD_TENS > 9 || LOAD_ONES < 0 || LOAD_ONES > 9 || CLK_FREQ_HZ < 10) begin : g_bad_param
    $error("bomb_countdown: LOAD digits must be 0..9 and CLK_FREQ_HZ must be >= 10");
  end

  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd0) return {t, o - 4'd1};
    else           return {t - 4'd1, 4'd9};
  endfunction

  logic [PW-1:0] prescaler;
  logic [PW-1:0] last;
  logic          hit;
  logic          at_zero;
  logic [6:0]    count_bin;

  always_comb begin
    last = LAST_FULL;
`ifdef COUNTDOWN_TURBO_EN
    if (turbo) last = LAST_TURBO;
`endif
  end

  // >= rather than == so a shorter limit taking effect mid-period still fires promptly
  assign hit         = (prescaler >= last);
  assign OneSecPulse = resetN & countLoadN & hit;

  assign at_zero   = (tens == 4'd0) && (ones == 4'd0);
  assign count_bin = {3'b000, tens} * 7'd10 + {3'b000, ones};
  assign timerEnd  = at_zero;
  assign lowTime   = !at_zero && (count_bin <= 7'(WARN_SECS));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescaler <= '0;
      tens      <= 4'(LOAD_TENS);
      ones      <= 4'(LOAD_ONES);
    end else if (!countLoadN) begin
      prescaler <= '0;
      tens      <= 4'(LOAD_TENS);
      ones      <= 4'(LOAD_ONES);
    end else begin
      // prescaler never stops: the FSM needs ticks while the count is paused
      if (hit) prescaler <= '0;
      else     prescaler <= prescaler + 1'b1;
      if (hit && countEnable && !at_zero) {tens, ones} <= bcd_dec(tens, ones);
    end
  end

endmodule
